// File: rtl/score_bcd_accum.sv
// Three-digit BCD score accumulator with hit-combo bonus and miss penalty.
// Pending credit/debit is queued and drained one BCD step per clock.
module score_bcd_accum #(
  parameter int COMBO_LEN = 5,
  parameter int BONUS     = 2,
  parameter int PENALTY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score_hund,
  output logic [3:0] score_tens,
  output logic [3:0] score_unit,
  output logic [3:0] combo,
  output logic       busy,
  output logic       sat
);

  typedef enum logic [1:0] {IDLE = 2'd0, INC = 2'd1, DEC = 2'd2} state_t;

  localparam logic [3:0]        COMBO_LAST = 4'(COMBO_LEN - 1);
  localparam logic signed [7:0] ADD_BONUS  = 8'(1 + BONUS);
  localparam logic signed [7:0] PEN        = 8'(PENALTY);
  localparam logic signed [7:0] PEND_MAX   = 8'sd31;

  state_t      state_q, state_d, mode_s;
  logic [11:0] score_q, score_d;
  logic [3:0]  combo_q, combo_d;
  logic [4:0]  pend_add_q, pend_add_d;
  logic [4:0]  pend_sub_q, pend_sub_d;
  logic        sat_q, sat_d;
  logic        busy_q, busy_d;

  logic              cap_hit_s, cap_miss_s;
  logic              drain_inc_s, drain_dec_s;
  logic              is_max_s, is_zero_s;
  logic signed [7:0] add_in_s, add_out_s, pen_s, net_add_s;
  logic signed [7:0] sub_in_s, sub_out_s, net_sub_s;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {h, t, u};
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd0) begin
      u = 4'd9;
      if (t == 4'd0) begin
        t = 4'd9;
        h = h - 4'd1;
      end else begin
        t = t - 4'd1;
      end
    end else begin
      u = u - 4'd1;
    end
    return {h, t, u};
  endfunction

  function automatic logic [4:0] clamp31(input logic signed [7:0] v);
    logic [4:0] r;
    if (v < 8'sd0) begin
      r = 5'd0;
    end else if (v > PEND_MAX) begin
      r = 5'd31;
    end else begin
      r = v[4:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      score_q    <= 12'h000;
      combo_q    <= 4'd0;
      pend_add_q <= 5'd0;
      pend_sub_q <= 5'd0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      pend_add_q <= pend_add_d;
      pend_sub_q <= pend_sub_d;
      sat_q      <= sat_d;
      busy_q     <= busy_d;
    end
  end

  // IDLE dispatches in the same cycle so a fresh credit drains on the next edge.
  always_comb begin
    case (state_q)
      IDLE: begin
        if (pend_add_q != 5'd0) begin
          mode_s = INC;
        end else if (pend_sub_q != 5'd0) begin
          mode_s = DEC;
        end else begin
          mode_s = IDLE;
        end
      end
      INC:     mode_s = INC;
      DEC:     mode_s = DEC;
      default: mode_s = IDLE;
    endcase
    drain_inc_s = (mode_s == INC) && (pend_add_q != 5'd0);
    drain_dec_s = (mode_s == DEC) && (pend_sub_q != 5'd0);
  end

  always_comb begin
    if (clear) begin
      state_d = IDLE;
    end else if ((mode_s == DEC) && (pend_sub_d != 5'd0)) begin
      state_d = DEC;
    end else if (pend_add_d != 5'd0) begin
      state_d = INC;
    end else if (pend_sub_d != 5'd0) begin
      state_d = DEC;
    end else begin
      state_d = IDLE;
    end
  end

  // Capture and drain are folded into one signed net per counter; a miss that
  // overdraws pending credit spills the remainder into pending debit.
  always_comb begin
    cap_hit_s  = en && hit && !miss;
    cap_miss_s = en && miss;
    is_max_s   = (score_q == 12'h999);
    is_zero_s  = (score_q == 12'h000);

    if (cap_hit_s) begin
      add_in_s = (combo_q == COMBO_LAST) ? ADD_BONUS : 8'sd1;
    end else begin
      add_in_s = 8'sd0;
    end
    pen_s = cap_miss_s ? PEN : 8'sd0;

    if (drain_inc_s) begin
      add_out_s = is_max_s ? $signed({3'b000, pend_add_q}) : 8'sd1;
    end else begin
      add_out_s = 8'sd0;
    end
    if (drain_dec_s) begin
      sub_out_s = is_zero_s ? $signed({3'b000, pend_sub_q}) : 8'sd1;
    end else begin
      sub_out_s = 8'sd0;
    end

    net_add_s = $signed({3'b000, pend_add_q}) + add_in_s - add_out_s - pen_s;
    if (net_add_s < 8'sd0) begin
      sub_in_s = 8'sd0 - net_add_s;
    end else begin
      sub_in_s = 8'sd0;
    end
    net_sub_s = $signed({3'b000, pend_sub_q}) + sub_in_s - sub_out_s;

    if (cap_miss_s) begin
      combo_d = 4'd0;
    end else if (cap_hit_s) begin
      combo_d = (combo_q == COMBO_LAST) ? 4'd0 : combo_q + 4'd1;
    end else begin
      combo_d = combo_q;
    end

    if (drain_inc_s && !is_max_s) begin
      score_d = bcd_inc(score_q);
    end else if (drain_dec_s && !is_zero_s) begin
      score_d = bcd_dec(score_q);
    end else begin
      score_d = score_q;
    end

    pend_add_d = clamp31(net_add_s);
    pend_sub_d = clamp31(net_sub_s);
    sat_d      = sat_q || (drain_inc_s && is_max_s);

    if (clear) begin
      score_d    = 12'h000;
      combo_d    = 4'd0;
      pend_add_d = 5'd0;
      pend_sub_d = 5'd0;
      sat_d      = 1'b0;
    end else begin
      score_d = score_d;
    end
    busy_d = (pend_add_d != 5'd0) || (pend_sub_d != 5'd0);
  end

  assign score_hund = score_q[11:8];
  assign score_tens = score_q[7:4];
  assign score_unit = score_q[3:0];
  assign combo      = combo_q;
  assign busy       = busy_q;
  assign sat        = sat_q;

endmodule
